// File: rtl/addsub_serial_nb.sv
// addsub_serial_nb: digit-serial add/subtract with valid/ready handshakes.
// One DIGIT-bit adder slice and a registered carry process the operands
// LSB digit first over N = WIDTH/DIGIT cycles, then the result and flags
// are held until the consumer takes them.
//
// Handshake semantics: an operand set transfers on a rising edge where
// in_valid && in_ready; a result transfers on a rising edge where
// out_valid && out_ready. in_ready is high only in IDLE (and never while
// rst_n is low). out_valid is high only in DONE, and the outputs do not
// change while it is high. Inputs are ignored outside the accept edge.
module addsub_serial_nb #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             c_in,
  input  logic             add_sub_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Operands must split into a whole number of digits.
  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("addsub_serial_nb: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;      // A, shifted right one digit per cycle
  logic [WIDTH-1:0] b_sr;      // B_eff (inverted B when subtracting)
  logic [WIDTH-1:0] res_sr;    // sum digits shifted in from the top
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   slice;
  logic [DIGIT-1:0] sum_dig;
  logic [WIDTH-1:0] res_next;
  logic             last_dig;
  logic             ovf_next;

  // Single digit adder slice plus next-result and flag preview.
  always_comb begin
    slice    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]}
             + {{DIGIT{1'b0}}, carry};
    sum_dig  = slice[DIGIT-1:0];
    res_next = (res_sr >> DIGIT) | (WIDTH'(sum_dig) << (WIDTH - DIGIT));
    last_dig = (cnt == CW'(N - 1));
    // On the last digit the low digit of a_sr/b_sr holds the operand MSBs.
    ovf_next = (a_sr[DIGIT-1] == b_sr[DIGIT-1]) &&
               (sum_dig[DIGIT-1] != a_sr[DIGIT-1]);
  end

  assign in_ready = rst_n && (state == IDLE);

  // Control FSM and datapath registers; results are registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      out       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= inA;
            b_sr  <= add_sub_sel ? ~inB : inB;
            carry <= add_sub_sel ? ~c_in : c_in;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          carry  <= slice[DIGIT];
          cnt    <= cnt + 1'b1;
          if (last_dig) begin
            out       <= res_next;
            c_out     <= slice[DIGIT];
            ovf       <= ovf_next;
            zero      <= ~|res_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial_nb.sv
// Testbench for addsub_serial_nb: directed table, randomized ops against a
// signed/unsigned arithmetic model, backpressure, reset mid-operation and a
// small parameter sweep.
module tb_addsub_serial_nb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, c_in, add_sub_sel;
  logic        out_valid, out_ready, c_out, ovf, zero;
  logic [15:0] inA, inB, out;

  int total = 0;
  int bad   = 0;
  time last_acc = 0, prev_acc = 0;

  addsub_serial_nb #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inA(inA), .inB(inB), .c_in(c_in), .add_sub_sel(add_sub_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .c_out(c_out), .ovf(ovf), .zero(zero)
  );

  // Parameter sweep instances (add only, shared valid/ready).
  logic        s_valid, s_ready;
  logic [31:0] a32, b32, o32;
  logic [15:0] aw, bw, ow, a1, b1, o1;
  logic        ir32, v32, co32, f32, z32;
  logic        irw, vw, cow, fw, zw;
  logic        ir1, v1, co1, f1, z1;

  addsub_serial_nb #(.WIDTH(32), .DIGIT(8)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(ir32),
    .inA(a32), .inB(b32), .c_in(1'b0), .add_sub_sel(1'b0),
    .out_valid(v32), .out_ready(s_ready), .out(o32),
    .c_out(co32), .ovf(f32), .zero(z32)
  );
  addsub_serial_nb #(.WIDTH(16), .DIGIT(16)) dw (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(irw),
    .inA(aw), .inB(bw), .c_in(1'b0), .add_sub_sel(1'b0),
    .out_valid(vw), .out_ready(s_ready), .out(ow),
    .c_out(cow), .ovf(fw), .zero(zw)
  );
  addsub_serial_nb #(.WIDTH(16), .DIGIT(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(ir1),
    .inA(a1), .inB(b1), .c_in(1'b0), .add_sub_sel(1'b0),
    .out_valid(v1), .out_ready(s_ready), .out(o1),
    .c_out(co1), .ovf(f1), .zero(z1)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {c_out, ovf, zero, out}.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sel);
    int sa, sb, s;
    logic [16:0] u;
    logic co, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sel) begin
      u  = {1'b0, a} + {1'b0, b} + 17'(ci);
      co = u[16];
      s  = sa + sb + int'(ci);
    end else begin
      u  = {1'b0, a} - {1'b0, b} - 17'(ci);
      co = (int'(a) >= int'(b) + int'(ci));  // carry set means no borrow
      s  = sa - sb - int'(ci);
    end
    ov = (s > 32767) || (s < -32768);
    return {co, ov, (u[15:0] == 16'h0), u[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble();
    in_valid    = 1'($urandom_range(0, 1));
    inA         = 16'($urandom);
    inB         = 16'($urandom);
    c_in        = 1'($urandom_range(0, 1));
    add_sub_sel = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s_valid = 1'b0; s_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("in_ready_during_reset", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction; hold = cycles out_ready stays low after out_valid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sel, input int hold,
                        output logic [15:0] r, output logic co, output logic ov,
                        output logic z, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    inA = a; inB = b; c_in = ci; add_sub_sel = sel; in_valid = 1'b1;
    @(posedge clk);
    prev_acc = last_acc;
    last_acc = $time;
    lat = 0;
    do begin
      @(negedge clk); scramble();
      @(posedge clk); lat++;
      #1;
    end while (!out_valid && lat < 100);
    r = out; co = c_out; ov = ovf; z = zero;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); scramble();
      @(posedge clk); #1;
      check("hold_out", 32'(out), 32'(r));
      check("hold_flags", 32'({c_out, ovf, zero}), 32'({co, ov, z}));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("valid_after_handshake", 32'(out_valid), 32'd0);
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    check("out_retained", 32'(out), 32'(r));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [15:0] a, b;
    logic        ci, sel;
    logic [15:0] r;
    logic        co, ov, z;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic        co, ov, z;
    logic [18:0] exp;
    int          lat;
    int          l32, lw, l1;

    vecs[0] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7F93, 16'h1234, 1'b0, 1'b0, 16'h91C7, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h8765, 16'hA001, 1'b0, 1'b1, 16'hE764, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{16'h5678, 16'h0001, 1'b1, 1'b1, 16'h5676, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};

    inA = '0; inB = '0; c_in = 1'b0; add_sub_sel = 1'b0;
    a32 = '0; b32 = '0; aw = '0; bw = '0; a1 = '0; b1 = '0;
    do_reset();

    // Reset state
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_flags", 32'({c_out, ovf, zero, out_valid}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back table: handshake on the first DONE edge, period N+2.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sel, 0, r, co, ov, z, lat);
      check($sformatf("vec%0d_out", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_cout", i), 32'(co), 32'(vecs[i].co));
      check($sformatf("vec%0d_ovf", i), 32'(ov), 32'(vecs[i].ov));
      check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      if (i > 0) check($sformatf("vec%0d_period", i), 32'((last_acc - prev_acc) / 10), 32'd6);
    end

    // Backpressure: 5 cycles of out_ready=0 with inputs toggling.
    run_op(16'h7F93, 16'h1234, 1'b0, 1'b0, 5, r, co, ov, z, lat);
    check("bp_out", 32'(r), 32'h91C7);
    check("bp_flags", 32'({co, ov, z}), 32'b010);

    // Randomized ops against the model.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a, b;
      logic ci, sel;
      a = 16'($urandom); b = 16'($urandom);
      if (i % 5 == 0) b = a;
      ci = 1'($urandom_range(0, 1)); sel = 1'($urandom_range(0, 1));
      exp = model(a, b, ci, sel);
      run_op(a, b, ci, sel, $urandom_range(0, 3), r, co, ov, z, lat);
      check($sformatf("rnd%0d_result", i), 32'({co, ov, z, r}), 32'(exp));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
    end

    // Reset in CALC with digit counter at 2 discards the op.
    @(negedge clk);
    inA = 16'h1111; inB = 16'h2222; c_in = 1'b0; add_sub_sel = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out", 32'(out), 32'd0);
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, r, co, ov, z, lat);
    check("midrst_fresh_out", 32'(r), 32'h0002);
    check("midrst_fresh_latency", 32'(lat), 32'd4);

    // Parameter sweep: all three accepted on the same edge.
    @(negedge clk);
    a32 = 32'h7FFFFFFF; b32 = 32'h00000001;
    aw  = 16'h1234;     bw  = 16'h1234;
    a1  = 16'h7F93;     b1  = 16'h1234;
    check("sweep_ready", 32'({ir32, irw, ir1}), 32'b111);
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    l32 = 0; lw = 0; l1 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (v32 && l32 == 0) l32 = k;
      if (vw && lw == 0) lw = k;
      if (v1 && l1 == 0) l1 = k;
    end
    check("w32_out", o32, 32'h80000000);
    check("w32_ovf", 32'(f32), 32'd1);
    check("w32_latency", 32'(l32), 32'd4);
    check("w16d16_out", 32'(ow), 32'h2468);
    check("w16d16_latency", 32'(lw), 32'd1);
    check("w16d1_out", 32'(o1), 32'h91C7);
    check("w16d1_ovf", 32'(f1), 32'd1);
    check("w16d1_latency", 32'(l1), 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
